// File: rtl/red_pitaya_adc_spi_pkg.sv
// Shared types and helpers for the Red Pitaya ADC SPI arbiter.
package red_pitaya_adc_spi_pkg;

    localparam int unsigned SPI_WORD_W = 16;
    localparam int unsigned MAX_REQ    = 8;
    localparam int unsigned MAX_ID_W   = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2,
        GAP   = 2'd3
    } spi_state_e;

    // First set bit of valid, searching upward from ptr with wrap at n.
    function automatic logic [MAX_ID_W-1:0] rr_pick(
        input logic [MAX_REQ-1:0]  valid,
        input logic [MAX_ID_W-1:0] ptr,
        input int unsigned         n
    );
        logic [MAX_ID_W-1:0] pick;
        logic                found;
        int unsigned         idx;
        pick  = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            idx = 32'(ptr) + i;
            if (idx >= n) idx = idx - n;
            if ((i < n) && !found && valid[idx[MAX_ID_W-1:0]]) begin
                pick  = idx[MAX_ID_W-1:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/red_pitaya_adc_spi_shifter.sv
// Serializes one 16-bit word onto n_cs/sclk/sdio, then holds and gaps chip select.
module red_pitaya_adc_spi_shifter
    import red_pitaya_adc_spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned CS_GAP  = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [SPI_WORD_W-1:0] word,
    output logic                  n_cs,
    output logic                  sclk,
    output logic                  sdio,
    output logic                  done,
    output logic                  busy
);

    localparam int unsigned BIT_LEN = 2 * CLK_DIV;
    localparam int unsigned CNT_MAX = (BIT_LEN > CS_GAP) ? BIT_LEN : CS_GAP;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned BIT_W   = $clog2(SPI_WORD_W);

    spi_state_e            state, state_n;
    logic [CNT_W-1:0]      cnt, cnt_n;
    logic [BIT_W-1:0]      bit_idx, bit_idx_n;
    logic [SPI_WORD_W-1:0] shreg, shreg_n;
    logic                  n_cs_n, sclk_n, sdio_n, done_n, busy_n;

    // State, counters and registered SPI pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            n_cs    <= 1'b1;
            sclk    <= 1'b0;
            sdio    <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_idx_n;
            shreg   <= shreg_n;
            n_cs    <= n_cs_n;
            sclk    <= sclk_n;
            sdio    <= sdio_n;
            done    <= done_n;
            busy    <= busy_n;
        end
    end

    // Phase sequencing; pin values are derived from the next phase so they register in step.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n   = SHIFT;
                    cnt_n     = '0;
                    bit_idx_n = '0;
                    shreg_n   = word;
                end
            end
            SHIFT: begin
                if (cnt == CNT_W'(BIT_LEN - 1)) begin
                    cnt_n = '0;
                    if (bit_idx == BIT_W'(SPI_WORD_W - 1)) begin
                        state_n = HOLD;
                    end else begin
                        bit_idx_n = bit_idx + BIT_W'(1);
                        shreg_n   = {shreg[SPI_WORD_W-2:0], 1'b0};
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            HOLD: begin
                if (cnt == CNT_W'(CLK_DIV - 1)) begin
                    state_n = GAP;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt == CNT_W'(CS_GAP - 1)) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        n_cs_n = !((state_n == SHIFT) || (state_n == HOLD));
        sclk_n = (state_n == SHIFT) && (cnt_n >= CNT_W'(CLK_DIV));
        sdio_n = ((state_n == SHIFT) || (state_n == HOLD)) ? shreg_n[SPI_WORD_W-1] : 1'b0;
        done_n = (state_n == GAP) && (state != GAP);
        busy_n = (state_n != IDLE);
    end

endmodule

// File: rtl/red_pitaya_adc_spi_arb.sv
// Round-robin arbiter sharing the ADC 3-wire SPI config port between requesters.
// Optional build macro ADC_SPI_ARB_LOCK_EN keeps the grant on one requester across words.
module red_pitaya_adc_spi_arb
    import red_pitaya_adc_spi_pkg::*;
#(
    parameter int unsigned N_REQ   = 3,
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned CS_GAP  = 10
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [SPI_WORD_W*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]            req_lock,
    output logic [N_REQ-1:0]            req_ready,
    output logic                        busy,
    output logic [$clog2(N_REQ)-1:0]    grant_id,
    output logic                        done,
    output logic                        n_cs,
    output logic                        sclk,
    output logic                        sdio
);

    localparam int unsigned ID_W = $clog2(N_REQ);

    logic [ID_W-1:0]       rr_ptr;
    logic [N_REQ-1:0]      cand_c;
    logic [ID_W-1:0]       pick_c;
    logic                  start_c;
    logic [SPI_WORD_W-1:0] word_c;

`ifdef ADC_SPI_ARB_LOCK_EN
    logic            lock_on;
    logic [ID_W-1:0] lock_id;

    // While locked, only the lock owner may win.
    always_comb begin
        cand_c = req_valid;
        if (lock_on) cand_c = req_valid & (N_REQ'(1) << lock_id);
    end

    // Lock follows the req_lock bit of every accepted word.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            lock_on <= 1'b0;
            lock_id <= '0;
        end else if (start_c) begin
            lock_on <= req_lock[pick_c];
            lock_id <= pick_c;
        end
    end
`else
    logic unused_lock;
    assign unused_lock = ^req_lock;

    // Every word re-arbitrates among all valid requesters.
    always_comb cand_c = req_valid;
`endif

    // Winner selection and word mux; accept only while the serializer is idle.
    always_comb begin
        pick_c  = ID_W'(rr_pick(MAX_REQ'(cand_c), MAX_ID_W'(rr_ptr), N_REQ));
        start_c = !busy && (|cand_c);
        word_c  = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (pick_c == ID_W'(k)) word_c = req_data[k*SPI_WORD_W +: SPI_WORD_W];
        end
    end

    // Accept pulse, grant index and round-robin pointer.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            req_ready <= '0;
            grant_id  <= '0;
            rr_ptr    <= '0;
        end else begin
            req_ready <= start_c ? (N_REQ'(1) << pick_c) : '0;
            if (start_c) begin
                grant_id <= pick_c;
                rr_ptr   <= ((32'(pick_c) + 32'd1) >= N_REQ) ? '0 : pick_c + ID_W'(1);
            end
        end
    end

    red_pitaya_adc_spi_shifter #(
        .CLK_DIV (CLK_DIV),
        .CS_GAP  (CS_GAP)
    ) u_shifter (
        .clk   (aclk),
        .rst_n (aresetn),
        .start (start_c),
        .word  (word_c),
        .n_cs  (n_cs),
        .sclk  (sclk),
        .sdio  (sdio),
        .done  (done),
        .busy  (busy)
    );

endmodule

// File: doc/red_pitaya_adc_spi_arb.md
# red_pitaya_adc_spi_arb

Shares the Red Pitaya ADC's 3-wire write-only SPI configuration port between N_REQ requesters (boot sequencer, register bank, calibration FSM). Requests arrive as 16-bit words (address byte, then data byte, MSB first) on per-requester valid/ready handshakes. The block picks a winner round-robin, serializes the word on n_cs/sclk/sdio, enforces an inter-word chip-select gap, and reports which requester owns the bus.

## Interface
- N_REQ, 3: number of requesters, 2..8
- CLK_DIV, 4: aclk cycles per sclk half-period, ≥1 (default gives an 8-cycle sclk)
- CS_GAP, 10: aclk cycles n_cs stays high between words, ≥1
- aclk  in  1  system clock; all logic on its rising edge
- aresetn  in  1  asynchronous, active-low reset
- req_valid  in  N_REQ  request pending, one bit per requester
- req_data  in  16*N_REQ  flattened words; requester k uses [16k+15:16k]
- req_lock  in  N_REQ  keep grant after this word (used only with the lock feature)
- req_ready  out  N_REQ  one-cycle accept pulse, at most one bit high
- busy  out  1  high from accept until the end of GAP
- grant_id  out  $clog2(N_REQ)  index of the current or last winner
- done  out  1  one-cycle pulse when n_cs rises after a word
- n_cs  out  1  ADC chip select, active low
- sclk  out  1  SPI clock, idles low
- sdio  out  1  serial data to ADC

## Operation
- States: IDLE, SHIFT, HOLD, GAP.
- IDLE: if any req_valid is high, choose the first set bit searching from rr_ptr upward with wrap-around. In that cycle, pulse req_ready[k], latch req_data[k], set grant_id=k, rr_ptr=(k+1) mod N_REQ, and go to SHIFT. If no request is valid, stay in IDLE.
- SHIFT: 16 bits, bit 15 first. Each bit lasts 2*CLK_DIV cycles: sclk is low for the first CLK_DIV cycles and high for the second CLK_DIV cycles. sdio changes only at the start of the low half. n_cs is low throughout.
- HOLD: CLK_DIV cycles with sclk=0 and n_cs=0.
- GAP: n_cs=1 and sdio=0 for CS_GAP cycles. done pulses in the first GAP cycle. At the end of GAP, return to IDLE.
- Handshake: requesters hold req_valid and req_data stable until req_ready. A requester that drops req_valid early loses its slot, and no error is raised. req_ready is asserted only in IDLE.
- All outputs are registered.
- Reset values: n_cs=1, sclk=0, sdio=0, req_ready=0, busy=0, done=0, grant_id=0, rr_ptr=0, state=IDLE.
- Asserting aresetn low mid-word forces the reset values immediately. The in-flight word is discarded and is not retried.

## Timing
- n_cs falls in the cycle after the accept cycle.
- First sclk rising edge: CLK_DIV cycles after n_cs falls.
- Word length: 1 accept + 32*CLK_DIV + CLK_DIV + CS_GAP cycles. With defaults this is 143 cycles.
- Back-to-back words: the next accept happens in the first IDLE cycle after GAP. There are no extra idle cycles.
- Simultaneous requests: the winner is decided only by rr_ptr. A request that arrives during SHIFT, HOLD or GAP waits until the next IDLE.

## Configuration
- ADC_SPI_ARB_LOCK_EN defined:
  - If req_lock[k] is high in the accept cycle, the next IDLE considers only requester k and waits indefinitely for req_valid[k].
  - The lock is released when a word from k is accepted with req_lock[k]=0.
  - rr_ptr still advances past k on every accept.
  - Used for multi-word ADC register sequences.
- ADC_SPI_ARB_LOCK_EN not defined: the req_lock port remains but is ignored, and the grant re-arbitrates after every word.

## Structure
- Package red_pitaya_adc_spi_pkg holds:
  - the state enum
  - SPI_WORD_W=16
  - a round-robin priority-pick function (valid vector, pointer → index)
- Sub-module red_pitaya_adc_spi_shifter holds the serializer:
  - inputs: start, 16-bit word, CLK_DIV
  - outputs: n_cs, sclk, sdio, done
  - it owns the SHIFT/HOLD/GAP counters
- The top module keeps the arbitration logic, rr_ptr and the lock logic.

## Test plan
- Reset, then requester 0 sends 0x0100, 0x0201, 0x0302 and 0x0400 in sequence. The bench samples sdio on sclk rising edges and captures the word on n_cs rising. The captured words must match in order, each n_cs-low window must be 132 cycles, and each gap must be 10 cycles.
- req_valid=3'b101 asserted in the same cycle with rr_ptr=0 → requester 0 is granted first, then requester 2. grant_id reads 0 then 2, and req_ready[1] never pulses.
- All three requesters hold valid continuously → grants follow 0,1,2,0,1,2 with no requester granted twice in a row.
- aresetn pulsed low at bit 7 of word 0xA55A → n_cs=1, sclk=0 and busy=0 immediately. After release, a new word 0x1234 transfers cleanly.
- With ADC_SPI_ARB_LOCK_EN: requester 1 sends 0x0A01 with lock=1, then 0x0B02 with lock=0, while requester 0 is valid throughout. Order must be 1,1,0. Without the macro the order must be 1,0,1.
- No requests for 1000 cycles → busy=0, n_cs=1 and sclk=0 held, and no req_ready or done pulses.
